// File: rtl/axi_write_arbiter.sv
// Two-to-one AXI4 write-path arbiter.
// AW requests from two masters are arbitrated round-robin into a single
// registered AW stage. The grant order is remembered in a small FIFO so that
// W beats are forwarded in the same order as the bursts were granted.
// B responses are steered back using the master-index bit prepended to the ID.
module axi_write_arbiter #(
    parameter int LOG2_WQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    // master 0 write address
    input  logic [63:0]  s0_axi_awaddr,
    input  logic [1:0]   s0_axi_awburst,
    input  logic [3:0]   s0_axi_awcache,
    input  logic [5:0]   s0_axi_awid,
    input  logic [7:0]   s0_axi_awlen,
    input  logic         s0_axi_awlock,
    input  logic [2:0]   s0_axi_awprot,
    input  logic [3:0]   s0_axi_awqos,
    input  logic [3:0]   s0_axi_awregion,
    input  logic [2:0]   s0_axi_awsize,
    input  logic         s0_axi_awvalid,
    output logic         s0_axi_awready,
    // master 0 write data
    input  logic [511:0] s0_axi_wdata,
    input  logic [63:0]  s0_axi_wstrb,
    input  logic         s0_axi_wlast,
    input  logic         s0_axi_wvalid,
    output logic         s0_axi_wready,
    // master 0 write response
    output logic [5:0]   s0_axi_bid,
    output logic [1:0]   s0_axi_bresp,
    output logic         s0_axi_bvalid,
    input  logic         s0_axi_bready,
    // master 1 write address
    input  logic [63:0]  s1_axi_awaddr,
    input  logic [1:0]   s1_axi_awburst,
    input  logic [3:0]   s1_axi_awcache,
    input  logic [5:0]   s1_axi_awid,
    input  logic [7:0]   s1_axi_awlen,
    input  logic         s1_axi_awlock,
    input  logic [2:0]   s1_axi_awprot,
    input  logic [3:0]   s1_axi_awqos,
    input  logic [3:0]   s1_axi_awregion,
    input  logic [2:0]   s1_axi_awsize,
    input  logic         s1_axi_awvalid,
    output logic         s1_axi_awready,
    // master 1 write data
    input  logic [511:0] s1_axi_wdata,
    input  logic [63:0]  s1_axi_wstrb,
    input  logic         s1_axi_wlast,
    input  logic         s1_axi_wvalid,
    output logic         s1_axi_wready,
    // master 1 write response
    output logic [5:0]   s1_axi_bid,
    output logic [1:0]   s1_axi_bresp,
    output logic         s1_axi_bvalid,
    input  logic         s1_axi_bready,
    // downstream write address (registered)
    output logic [63:0]  m_axi_awaddr,
    output logic [1:0]   m_axi_awburst,
    output logic [3:0]   m_axi_awcache,
    output logic [6:0]   m_axi_awid,
    output logic [7:0]   m_axi_awlen,
    output logic         m_axi_awlock,
    output logic [2:0]   m_axi_awprot,
    output logic [3:0]   m_axi_awqos,
    output logic [3:0]   m_axi_awregion,
    output logic [2:0]   m_axi_awsize,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    // downstream write data
    output logic [511:0] m_axi_wdata,
    output logic [63:0]  m_axi_wstrb,
    output logic         m_axi_wlast,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    // downstream write response
    input  logic [6:0]   m_axi_bid,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready
);

    localparam int WQ_DEPTH = 1 << LOG2_WQ_DEPTH;
    localparam logic [LOG2_WQ_DEPTH:0] WQ_FULL = WQ_DEPTH[LOG2_WQ_DEPTH:0];

    logic                     aw_full_q;
    logic                     prio_q;
    logic                     arb_en;
    logic                     grant_idx;
    logic                     grant_vld;

    logic [WQ_DEPTH-1:0]      wq_mem;
    logic [LOG2_WQ_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_WQ_DEPTH-1:0] rd_ptr_q;
    logic [LOG2_WQ_DEPTH:0]   count_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     sel;

    assign m_axi_awvalid = aw_full_q;
    assign fifo_full     = (count_q == WQ_FULL);
    assign fifo_empty    = (count_q == '0);
    assign sel           = wq_mem[rd_ptr_q];
    assign fifo_push     = grant_vld;
    assign fifo_pop      = m_axi_wvalid && m_axi_wready && m_axi_wlast;

    // Pick one AW requester; awready is gated by reset so it reads 0 while reset is held.
    always_comb begin
        arb_en         = !reset && !aw_full_q && !fifo_full;
        grant_idx      = 1'b0;
        if (s0_axi_awvalid && s1_axi_awvalid) begin
            grant_idx = prio_q;
        end else if (s1_axi_awvalid) begin
            grant_idx = 1'b1;
        end
        grant_vld      = arb_en && (s0_axi_awvalid || s1_axi_awvalid);
        s0_axi_awready = grant_vld && !grant_idx;
        s1_axi_awready = grant_vld && grant_idx;
    end

    // Holding register: load on accept, release on downstream handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full_q      <= 1'b0;
            m_axi_awaddr   <= '0;
            m_axi_awburst  <= '0;
            m_axi_awcache  <= '0;
            m_axi_awid     <= '0;
            m_axi_awlen    <= '0;
            m_axi_awlock   <= 1'b0;
            m_axi_awprot   <= '0;
            m_axi_awqos    <= '0;
            m_axi_awregion <= '0;
            m_axi_awsize   <= '0;
        end else if (grant_vld) begin
            aw_full_q      <= 1'b1;
            m_axi_awaddr   <= grant_idx ? s1_axi_awaddr   : s0_axi_awaddr;
            m_axi_awburst  <= grant_idx ? s1_axi_awburst  : s0_axi_awburst;
            m_axi_awcache  <= grant_idx ? s1_axi_awcache  : s0_axi_awcache;
            m_axi_awid     <= {grant_idx, grant_idx ? s1_axi_awid : s0_axi_awid};
            m_axi_awlen    <= grant_idx ? s1_axi_awlen    : s0_axi_awlen;
            m_axi_awlock   <= grant_idx ? s1_axi_awlock   : s0_axi_awlock;
            m_axi_awprot   <= grant_idx ? s1_axi_awprot   : s0_axi_awprot;
            m_axi_awqos    <= grant_idx ? s1_axi_awqos    : s0_axi_awqos;
            m_axi_awregion <= grant_idx ? s1_axi_awregion : s0_axi_awregion;
            m_axi_awsize   <= grant_idx ? s1_axi_awsize   : s0_axi_awsize;
        end else if (aw_full_q && m_axi_awready) begin
            aw_full_q      <= 1'b0;
        end
    end

    // Round-robin pointer: after each grant, favour the master that did not win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (grant_vld) begin
            prio_q <= ~grant_idx;
        end
    end

    // Grant-order FIFO: one bit per accepted burst, popped on the last W beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_mem   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) begin
                wq_mem[wr_ptr_q] <= grant_idx;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!fifo_push && fifo_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // W path: forward the master at the head of the grant FIFO, hold the other.
    always_comb begin
        m_axi_wdata   = sel ? s1_axi_wdata : s0_axi_wdata;
        m_axi_wstrb   = sel ? s1_axi_wstrb : s0_axi_wstrb;
        m_axi_wlast   = sel ? s1_axi_wlast : s0_axi_wlast;
        m_axi_wvalid  = !fifo_empty && (sel ? s1_axi_wvalid : s0_axi_wvalid);
        s0_axi_wready = !fifo_empty && !sel && m_axi_wready;
        s1_axi_wready = !fifo_empty && sel && m_axi_wready;
    end

    // B path: steer by the prepended master-index bit, no state involved.
    always_comb begin
        s0_axi_bvalid = m_axi_bvalid && !m_axi_bid[6];
        s1_axi_bvalid = m_axi_bvalid && m_axi_bid[6];
        s0_axi_bid    = m_axi_bid[5:0];
        s1_axi_bid    = m_axi_bid[5:0];
        s0_axi_bresp  = m_axi_bresp;
        s1_axi_bresp  = m_axi_bresp;
        m_axi_bready  = m_axi_bid[6] ? s1_axi_bready : s0_axi_bready;
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Testbench for axi_write_arbiter: B-path vector table, directed sequences for
// the multi-cycle corner cases, and a randomized run against a transaction-level
// reference model (grant queue, holding-register flag, round-robin pointer).
module tb_axi_write_arbiter;

    localparam int WQ_DEPTH = 4;

    typedef struct {
        logic       bvalid;
        logic [6:0] bid;
        logic [1:0] bresp;
        logic       b0ready;
        logic       b1ready;
        logic       exp_b0valid;
        logic       exp_b1valid;
        logic [5:0] exp_bid;
        logic [1:0] exp_bresp;
        logic       exp_bready;
    } b_vec_t;

    logic         clk = 1'b0;
    logic         reset;

    logic [63:0]  s_awaddr   [2];
    logic [1:0]   s_awburst  [2];
    logic [3:0]   s_awcache  [2];
    logic [5:0]   s_awid     [2];
    logic [7:0]   s_awlen    [2];
    logic         s_awlock   [2];
    logic [2:0]   s_awprot   [2];
    logic [3:0]   s_awqos    [2];
    logic [3:0]   s_awregion [2];
    logic [2:0]   s_awsize   [2];
    logic         s_awvalid  [2];
    logic         s_awready  [2];
    logic [511:0] s_wdata    [2];
    logic [63:0]  s_wstrb    [2];
    logic         s_wlast    [2];
    logic         s_wvalid   [2];
    logic         s_wready   [2];
    logic [5:0]   s_bid      [2];
    logic [1:0]   s_bresp    [2];
    logic         s_bvalid   [2];
    logic         s_bready   [2];

    logic [63:0]  m_awaddr;
    logic [1:0]   m_awburst;
    logic [3:0]   m_awcache;
    logic [6:0]   m_awid;
    logic [7:0]   m_awlen;
    logic         m_awlock;
    logic [2:0]   m_awprot;
    logic [3:0]   m_awqos;
    logic [3:0]   m_awregion;
    logic [2:0]   m_awsize;
    logic         m_awvalid;
    logic         m_awready;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wlast;
    logic         m_wvalid;
    logic         m_wready;
    logic [6:0]   m_bid;
    logic [1:0]   m_bresp;
    logic         m_bvalid;
    logic         m_bready;

    logic [92:0]  m_pack;
    assign m_pack = {m_awaddr, m_awburst, m_awcache, m_awlen, m_awlock,
                     m_awprot, m_awqos, m_awregion, m_awsize};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_write_arbiter #(.LOG2_WQ_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awburst(s_awburst[0]), .s0_axi_awcache(s_awcache[0]),
        .s0_axi_awid(s_awid[0]), .s0_axi_awlen(s_awlen[0]), .s0_axi_awlock(s_awlock[0]),
        .s0_axi_awprot(s_awprot[0]), .s0_axi_awqos(s_awqos[0]), .s0_axi_awregion(s_awregion[0]),
        .s0_axi_awsize(s_awsize[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
        .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wlast(s_wlast[0]),
        .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
        .s0_axi_bid(s_bid[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
        .s0_axi_bready(s_bready[0]),
        .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awburst(s_awburst[1]), .s1_axi_awcache(s_awcache[1]),
        .s1_axi_awid(s_awid[1]), .s1_axi_awlen(s_awlen[1]), .s1_axi_awlock(s_awlock[1]),
        .s1_axi_awprot(s_awprot[1]), .s1_axi_awqos(s_awqos[1]), .s1_axi_awregion(s_awregion[1]),
        .s1_axi_awsize(s_awsize[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
        .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wlast(s_wlast[1]),
        .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
        .s1_axi_bid(s_bid[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
        .s1_axi_bready(s_bready[1]),
        .m_axi_awaddr(m_awaddr), .m_axi_awburst(m_awburst), .m_axi_awcache(m_awcache),
        .m_axi_awid(m_awid), .m_axi_awlen(m_awlen), .m_axi_awlock(m_awlock),
        .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos), .m_axi_awregion(m_awregion),
        .m_axi_awsize(m_awsize), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready)
    );

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input b_vec_t v);
        m_bvalid    = v.bvalid;
        m_bid       = v.bid;
        m_bresp     = v.bresp;
        s_bready[0] = v.b0ready;
        s_bready[1] = v.b1ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [92:0] s_pack(input int i);
        return {s_awaddr[i], s_awburst[i], s_awcache[i], s_awlen[i], s_awlock[i],
                s_awprot[i], s_awqos[i], s_awregion[i], s_awsize[i]};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic randomize_aw(input int i);
        s_awaddr[i]   = {$urandom(), $urandom()};
        s_awburst[i]  = 2'($urandom());
        s_awcache[i]  = 4'($urandom());
        s_awid[i]     = 6'($urandom());
        s_awlen[i]    = 8'($urandom());
        s_awlock[i]   = 1'($urandom());
        s_awprot[i]   = 3'($urandom());
        s_awqos[i]    = 4'($urandom());
        s_awregion[i] = 4'($urandom());
        s_awsize[i]   = 3'($urandom());
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_awburst[i] = '0; s_awcache[i] = '0; s_awid[i] = '0;
            s_awlen[i] = '0; s_awlock[i] = 1'b0; s_awprot[i] = '0; s_awqos[i] = '0;
            s_awregion[i] = '0; s_awsize[i] = '0; s_awvalid[i] = 1'b0;
            s_wdata[i] = '0; s_wstrb[i] = '0; s_wlast[i] = 1'b0; s_wvalid[i] = 1'b0;
            s_bready[i] = 1'b0;
        end
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bid     = '0;
        m_bresp   = '0;
        m_bvalid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    b_vec_t       b_table [6];
    int           n_grant, n_acc, n_obs, s0_beat, s1_beat;
    int           exp_tags [6];
    logic [6:0]   exp_id;
    logic [92:0]  pack_first;
    bit           mdl_q [$];
    bit           mdl_hold, mdl_ptr, has, sel, win, exp_acc, pop;
    logic [6:0]   mdl_id;
    logic [92:0]  mdl_pack;

    initial begin
        b_table[0] = '{1'b1, 7'h05, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05, 2'd0, 1'b1};
        b_table[1] = '{1'b1, 7'h45, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 6'h05, 2'd2, 1'b1};
        b_table[2] = '{1'b1, 7'h45, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 6'h05, 2'd2, 1'b0};
        b_table[3] = '{1'b0, 7'h3f, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h3f, 2'd1, 1'b1};
        b_table[4] = '{1'b1, 7'h7f, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3f, 2'd3, 1'b0};
        b_table[5] = '{1'b1, 7'h00, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 2'd1, 1'b0};
        exp_tags   = '{256, 257, 258, 259, 0, 1};

        // reset values, with requests pending while reset is held
        reset = 1'b0;
        clear_inputs();
        #1;
        reset = 1'b1;
        step();
        s_awvalid[0] = 1'b1; s_awvalid[1] = 1'b1; s_wvalid[0] = 1'b1; s_wvalid[1] = 1'b1;
        m_wready = 1'b1; m_awready = 1'b1;
        settle();
        checkOutput("rst_m_awvalid", m_awvalid, 0);
        checkOutput("rst_s0_awready", s_awready[0], 0);
        checkOutput("rst_s1_awready", s_awready[1], 0);
        checkOutput("rst_s0_wready", s_wready[0], 0);
        checkOutput("rst_s1_wready", s_wready[1], 0);
        checkOutput("rst_m_wvalid", m_wvalid, 0);

        // B path vectors, applied while reset is still held
        for (int v = 0; v < 6; v++) begin
            applyStimulus(b_table[v]);
            settle();
            checkOutput($sformatf("b_vec%0d_s0_bvalid", v), s_bvalid[0], b_table[v].exp_b0valid);
            checkOutput($sformatf("b_vec%0d_s1_bvalid", v), s_bvalid[1], b_table[v].exp_b1valid);
            checkOutput($sformatf("b_vec%0d_s0_bid", v), s_bid[0], b_table[v].exp_bid);
            checkOutput($sformatf("b_vec%0d_s1_bid", v), s_bid[1], b_table[v].exp_bid);
            checkOutput($sformatf("b_vec%0d_bresp", v), s_bresp[1], b_table[v].exp_bresp);
            checkOutput($sformatf("b_vec%0d_m_bready", v), m_bready, b_table[v].exp_bready);
        end
        do_reset();

        // single write from master 0
        s_awvalid[0] = 1'b1; s_awid[0] = 6'h05; s_awlen[0] = 8'd0; s_awaddr[0] = 64'h1000;
        settle();
        checkOutput("single_s0_awready", s_awready[0], 1);
        checkOutput("single_s1_awready", s_awready[1], 0);
        checkOutput("single_m_awvalid_early", m_awvalid, 0);
        step();
        s_awvalid[0] = 1'b0;
        s_wvalid[0] = 1'b1; s_wlast[0] = 1'b1; s_wdata[0] = 512'h1234_5678; m_wready = 1'b1;
        m_awready = 1'b1;
        settle();
        checkOutput("single_m_awvalid", m_awvalid, 1);
        checkOutput("single_m_awid", m_awid, 7'h05);
        checkOutput("single_m_awaddr", m_awaddr, 64'h1000);
        checkOutput("single_m_wvalid", m_wvalid, 1);
        checkOutput("single_s0_wready", s_wready[0], 1);
        checkOutput("single_m_wdata", m_wdata, 512'h1234_5678);
        step();
        m_awready = 1'b0;
        settle();
        checkOutput("single_aw_cleared", m_awvalid, 0);
        checkOutput("single_w_gated_empty", m_wvalid, 0);
        checkOutput("single_s0_wready_empty", s_wready[0], 0);
        m_bvalid = 1'b1; m_bid = 7'h05; s_bready[0] = 1'b1;
        settle();
        checkOutput("single_b_s0", s_bvalid[0], 1);
        checkOutput("single_b_s1", s_bvalid[1], 0);
        checkOutput("single_b_bready", m_bready, 1);
        do_reset();

        // contention: both masters request continuously
        s_awvalid[0] = 1'b1; s_awvalid[1] = 1'b1; s_awid[0] = 6'h10; s_awid[1] = 6'h20;
        s_wvalid[0] = 1'b1; s_wvalid[1] = 1'b1; s_wlast[0] = 1'b1; s_wlast[1] = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1;
        n_grant = 0;
        for (int cyc = 0; cyc < 40 && n_grant < 8; cyc++) begin
            settle();
            if (m_awvalid && m_awready) begin
                exp_id = (n_grant % 2 == 0) ? 7'h10 : 7'h60;
                checkOutput($sformatf("rr_awid%0d", n_grant), m_awid, exp_id);
                n_grant++;
            end
            if (n_grant == 8) begin
                s_awvalid[0] = 1'b0; s_awvalid[1] = 1'b0;
            end
            step();
        end
        checkOutput("rr_grant_count", n_grant, 8);
        do_reset();

        // W ordering: s1 burst of 4 granted before s0 burst of 2
        m_awready = 1'b1; m_wready = 1'b1;
        s_awvalid[1] = 1'b1; s_awid[1] = 6'h01; s_awlen[1] = 8'd3;
        settle();
        checkOutput("order_s1_aw_grant", s_awready[1], 1);
        step();
        s_awvalid[1] = 1'b0;
        s_awvalid[0] = 1'b1; s_awid[0] = 6'h02; s_awlen[0] = 8'd1;
        settle();
        checkOutput("order_s0_aw_blocked", s_awready[0], 0);
        step();
        settle();
        checkOutput("order_s0_aw_grant", s_awready[0], 1);
        step();
        s_awvalid[0] = 1'b0;
        s_wvalid[0] = 1'b1; s_wdata[0] = 512'd0; s_wlast[0] = 1'b0;
        settle();
        checkOutput("order_s0_waits_head", s_wready[0], 0);
        checkOutput("order_head_idle", m_wvalid, 0);
        step();
        s0_beat = 0; s1_beat = 0; n_obs = 0;
        for (int cyc = 0; cyc < 30 && n_obs < 6; cyc++) begin
            s_wvalid[0] = (s0_beat < 2); s_wdata[0] = 512'(s0_beat);       s_wlast[0] = (s0_beat == 1);
            s_wvalid[1] = (s1_beat < 4); s_wdata[1] = 512'(256 + s1_beat); s_wlast[1] = (s1_beat == 3);
            settle();
            if (s1_beat < 4) checkOutput("order_s0_wready_held", s_wready[0], 0);
            if (m_wvalid && m_wready) begin
                checkOutput($sformatf("order_beat%0d", n_obs), m_wdata, 512'(exp_tags[n_obs]));
                n_obs++;
            end
            if (s_wvalid[0] && s_wready[0]) s0_beat++;
            if (s_wvalid[1] && s_wready[1]) s1_beat++;
            step();
        end
        checkOutput("order_beat_count", n_obs, 6);
        do_reset();

        // FIFO full: four bursts outstanding with W stalled
        m_awready = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 20 && n_acc < 4; cyc++) begin
            s_awvalid[0] = 1'b1; s_awid[0] = 6'(n_acc);
            settle();
            if (s_awready[0]) n_acc++;
            step();
        end
        checkOutput("full_accepts", n_acc, 4);
        for (int cyc = 0; cyc < 4; cyc++) begin
            settle();
            checkOutput("full_blocked", s_awready[0], 0);
            step();
        end
        s_wvalid[0] = 1'b1; s_wlast[0] = 1'b1; m_wready = 1'b1;
        settle();
        checkOutput("full_pop_wready", s_wready[0], 1);
        checkOutput("full_no_push_on_pop", s_awready[0], 0);
        step();
        s_wvalid[0] = 1'b0; m_wready = 1'b0;
        settle();
        checkOutput("full_after_pop", s_awready[0], 1);
        step();
        do_reset();

        // backpressure: downstream AW stalled for 10 cycles
        s_awvalid[0] = 1'b1; randomize_aw(0); s_awid[0] = 6'h03;
        settle();
        checkOutput("bp_first_accept", s_awready[0], 1);
        pack_first = s_pack(0);
        step();
        s_awvalid[1] = 1'b1; s_awid[1] = 6'h2a;
        for (int cyc = 0; cyc < 10; cyc++) begin
            randomize_aw(0);
            settle();
            checkOutput("bp_m_awvalid", m_awvalid, 1);
            checkOutput("bp_m_awid", m_awid, 7'h03);
            checkOutput("bp_m_payload", m_pack, pack_first);
            checkOutput("bp_s0_awready", s_awready[0], 0);
            checkOutput("bp_s1_awready", s_awready[1], 0);
            step();
        end
        m_awready = 1'b1;
        step();
        settle();
        checkOutput("bp_rr_s1_after_release", s_awready[1], 1);
        checkOutput("bp_rr_s0_after_release", s_awready[0], 0);
        step();
        do_reset();

        // reset in the middle of a len=7 burst
        s_awvalid[0] = 1'b1; s_awid[0] = 6'h07; s_awlen[0] = 8'd7; m_wready = 1'b1;
        settle();
        checkOutput("mid_aw_grant", s_awready[0], 1);
        step();
        s_awvalid[0] = 1'b0;
        s_wvalid[0] = 1'b1; s_wlast[0] = 1'b0;
        settle();
        checkOutput("mid_beat0_wready", s_wready[0], 1);
        step();
        step();
        s_awvalid[0] = 1'b1; s_awvalid[1] = 1'b1;
        settle();
        checkOutput("mid_beat2_wready", s_wready[0], 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_m_awvalid", m_awvalid, 0);
        checkOutput("mid_rst_s0_awready", s_awready[0], 0);
        checkOutput("mid_rst_s1_awready", s_awready[1], 0);
        checkOutput("mid_rst_s0_wready", s_wready[0], 0);
        checkOutput("mid_rst_m_wvalid", m_wvalid, 0);
        step();
        clear_inputs();
        reset = 1'b0;
        s_awvalid[1] = 1'b1; s_awid[1] = 6'h11;
        settle();
        checkOutput("post_rst_s1_grant", s_awready[1], 1);
        checkOutput("post_rst_s0_idle", s_awready[0], 0);
        step();
        s_awvalid[1] = 1'b0;
        settle();
        checkOutput("post_rst_m_awid", m_awid, 7'h51);
        do_reset();

        // randomized run against the transaction-level model
        mdl_q.delete();
        mdl_hold = 1'b0; mdl_ptr = 1'b0; mdl_id = '0; mdl_pack = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                s_awvalid[i] = 1'($urandom_range(0, 1));
                randomize_aw(i);
                s_wvalid[i]  = 1'($urandom_range(0, 1));
                s_wlast[i]   = ($urandom_range(0, 2) == 0);
                s_wdata[i]   = rand512();
                s_wstrb[i]   = {$urandom(), $urandom()};
                s_bready[i]  = 1'($urandom_range(0, 1));
            end
            m_awready = ($urandom_range(0, 3) != 0);
            m_wready  = 1'($urandom_range(0, 1));
            m_bvalid  = 1'($urandom_range(0, 1));
            m_bid     = 7'($urandom());
            m_bresp   = 2'($urandom());
            settle();

            win     = (s_awvalid[0] && s_awvalid[1]) ? mdl_ptr : s_awvalid[1];
            exp_acc = !mdl_hold && (mdl_q.size() < WQ_DEPTH) && (s_awvalid[0] || s_awvalid[1]);
            checkOutput("rnd_s0_awready", s_awready[0], exp_acc && !win);
            checkOutput("rnd_s1_awready", s_awready[1], exp_acc && win);
            checkOutput("rnd_m_awvalid", m_awvalid, mdl_hold);
            if (mdl_hold) begin
                checkOutput("rnd_m_awid", m_awid, mdl_id);
                checkOutput("rnd_m_payload", m_pack, mdl_pack);
            end
            has = (mdl_q.size() > 0);
            sel = has ? mdl_q[0] : 1'b0;
            checkOutput("rnd_m_wvalid", m_wvalid, has && s_wvalid[sel]);
            checkOutput("rnd_s0_wready", s_wready[0], has && !sel && m_wready);
            checkOutput("rnd_s1_wready", s_wready[1], has && sel && m_wready);
            if (has) begin
                checkOutput("rnd_m_wdata", m_wdata, s_wdata[sel]);
                checkOutput("rnd_m_wstrb", m_wstrb, s_wstrb[sel]);
                checkOutput("rnd_m_wlast", m_wlast, s_wlast[sel]);
            end
            checkOutput("rnd_s0_bvalid", s_bvalid[0], m_bvalid && (m_bid[6] == 1'b0));
            checkOutput("rnd_s1_bvalid", s_bvalid[1], m_bvalid && (m_bid[6] == 1'b1));
            checkOutput("rnd_s0_bid", s_bid[0], m_bid[5:0]);
            checkOutput("rnd_s1_bresp", s_bresp[1], m_bresp);
            checkOutput("rnd_m_bready", m_bready, s_bready[m_bid[6]]);

            pop = has && s_wvalid[sel] && m_wready && s_wlast[sel];
            if (pop) void'(mdl_q.pop_front());
            if (exp_acc) begin
                mdl_q.push_back(win);
                mdl_hold = 1'b1;
                mdl_id   = {win, s_awid[win]};
                mdl_pack = s_pack(win);
                mdl_ptr  = !win;
            end else if (mdl_hold && m_awready) begin
                mdl_hold = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
